obj_affine_sequencer: RTL and testbench
=======================================

Name: obj_affine_sequencer

Overview:
- Per-object, per-scanline controller for the OBJ rotation/scaling datapath (`obj_rot_scale_unit`).
- On a start from the OAM scanner it fetches the object's four affine parameters (PA..PD) from OAM.
- It then sweeps the object's bounding box one screen column per cycle, driving the rot/scale unit.
- Each visible, non-transparent result is forwarded as a texel coordinate to the OBJ tile fetcher over a valid/ready handshake.

Parameters:
- SCREEN_W, 240, first off-screen column; columns >= SCREEN_W are never emitted.
- OAM_AW, 9, OAM halfword address width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin one object; accepted only in IDLE
- obj_x  in  9  bounding-box left screen column
- obj_y  in  8  bounding-box top row
- row  in  8  current scanline
- hsize  in  8  object width in pixels (8..64)
- vsize  in  8  object height in pixels (8..64)
- double_size  in  1  bounding box is 2x object size
- param_idx  in  5  affine parameter group 0..31
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse when the object completes
- oam_rd  out  1  OAM read strobe
- oam_addr  out  OAM_AW  OAM halfword address
- oam_rdata  in  16  read data, valid exactly 1 cycle after oam_rd
- rs_row, rs_col  out  8  to rot/scale unit
- rs_a, rs_b, rs_c, rs_d  out  16  latched PA..PD
- rs_obj_x  out  9  box center x
- rs_obj_y  out  8  box center y
- rs_hsize, rs_vsize  out  8  bounding-box dimensions
- rs_double  out  1  latched double_size
- rs_x, rs_y  in  6  texel coordinate from the unit (combinational)
- rs_transparent  in  1  texel outside the object
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accepts
- pix_screen_x  out  8  screen column
- pix_tex_x, pix_tex_y  out  6  texel coordinate

Behaviour:
- Reset: synchronous on the clock edge while reset_n=0, regardless of state.
  - State returns to IDLE.
  - busy, done, oam_rd, pix_valid = 0.
  - oam_addr, all rs_* and pix_* data outputs = 0.
- IDLE: start=1 registers all object inputs and moves to FETCH. start is ignored in any other state.
- Bounding box, computed at capture:
  - W = double_size ? hsize<<1 : hsize; H likewise from vsize.
  - rs_hsize=W, rs_vsize=H.
  - rs_obj_x = (obj_x + W/2) mod 512.
  - rs_obj_y = (obj_y + H/2) mod 256.
  - rs_row = row.
- FETCH, 4 cycles (k = 0..3):
  - oam_rd=1, oam_addr = 16*param_idx + 4*k + 3.
  - oam_rdata is captured into rs_a/b/c/d one cycle later.
  - The last capture coincides with the first RUN cycle. RUN starts with col=obj_x, so the first column is evaluated 5 cycles after start.
- RUN:
  - 9-bit column counter col runs obj_x..obj_x+W-1 modulo 512; rs_col = col[7:0].
  - Each cycle the output register is free (pix_valid=0, or pix_ready=1), the current column is evaluated.
  - Emit condition: col < SCREEN_W and rs_transparent=0. On emit, next cycle pix_valid=1, pix_screen_x=col[7:0], pix_tex_x=rs_x, pix_tex_y=rs_y.
  - Otherwise the column is skipped, pix_valid drops if it was consumed, and col still advances.
  - If the output register is held (pix_valid=1, pix_ready=0): col does not advance and all pix_* stay stable.
- After column W-1 is evaluated, move to DRAIN.
- DRAIN: wait until pix_valid=0 or pix_ready=1, then pulse done for one cycle and return to IDLE. busy falls in the same cycle done pulses.
- Throughput: 1 column/cycle without backpressure. Total object latency = 5 + W + 1 cycles (start accept to done).
- Arithmetic:
  - All column math is 9-bit and wraps; obj_x in 496..511 acts as a negative position.
  - rs_a..d are passed unmodified as signed 8.8 values; texel arithmetic belongs to the rot/scale unit.
- Row range is the scanner's responsibility; the unit's rs_transparent rejects out-of-range rows.

Decomposition:
- Shared package obj_pkg:
  - state enum {IDLE, FETCH, RUN, DRAIN}
  - SCREEN_W constant
  - OAM affine offset constants (stride 16, step 4, offset 3)
  - obj_attr_t struct for the captured object attributes
- Sub-module obj_pix_skid (single-entry valid/ready output register) is natural.
- The rot/scale unit is instantiated by the parent, not inside this block.

Test Plan:
- Identity (PA=PD=0x0100, PB=PC=0), hsize=vsize=8, obj_x=10, obj_y=20, row=23, param_idx=2 -> oam_addr 35,39,43,47 on four consecutive cycles. Then 8 pixels, screen_x 10..17, tex_x 0..7, tex_y 3, with done 14 cycles after start.
- Same with double_size=1 -> rs_hsize=16, rs_obj_x=18. Pixels only at screen_x 14..21, tex_x 0..7; columns 10..13 and 22..25 skipped; done 22 cycles after start.
- obj_x=236, identity 8x8 -> pixels 236..239 (tex_x 0..3) only. obj_x=508 -> pixels 0..3 with tex_x 4..7.
- pix_ready held low 3 cycles mid-run -> pix_* stable, no texel lost or duplicated, done delayed 3 cycles.
- start asserted while busy -> ignored, captured attributes unchanged. reset_n=0 in RUN -> next cycle IDLE, pix_valid=0, busy=0, no done pulse.

Source files
------------

// File: rtl/obj_pkg.sv
// Shared definitions for the OBJ affine sequencer slice.
//   - FSM state encodings
//   - screen width and OAM affine-parameter addressing constants
//   - obj_attr_t : object attributes captured when a start is accepted
//   - obj_pix_t  : one texel request handed to the tile fetcher
package obj_pkg;

  // FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // First off-screen column
  localparam int OBJ_SCREEN_W = 240;

  // PA..PD of group n sit at halfwords 16n+3, 16n+7, 16n+11, 16n+15
  localparam int OAM_AFF_STRIDE = 16;
  localparam int OAM_AFF_STEP   = 4;
  localparam int OAM_AFF_OFS    = 3;

  typedef struct packed {
    logic [7:0] row;   // scanline being rendered
    logic [7:0] w;     // bounding-box width
    logic [7:0] h;     // bounding-box height
    logic [8:0] cx;    // box center x (mod 512)
    logic [7:0] cy;    // box center y (mod 256)
    logic       dbl;   // double-size box
    logic [4:0] pidx;  // affine parameter group
  } obj_attr_t;

  typedef struct packed {
    logic [7:0] sx;    // screen column
    logic [5:0] tx;    // texel x
    logic [5:0] ty;    // texel y
  } obj_pix_t;

  // Halfword address of parameter k (0=PA .. 3=PD) in group pidx
  function automatic int aff_addr(logic [4:0] pidx, logic [1:0] k);
    return OAM_AFF_STRIDE * int'(pidx) + OAM_AFF_STEP * int'(k) + OAM_AFF_OFS;
  endfunction

endpackage

// File: rtl/obj_pix_skid.sv
// Single-entry valid/ready output register for texel requests.
// Ports:
//   clock_i, reset_n_i : clock, synchronous active-low reset
//   ld_i               : upstream is evaluating a column this cycle
//   emit_i             : the evaluated column produces a texel
//   pix_i              : texel payload for the evaluated column
//   ready_i            : downstream accepts the held texel
//   free_o             : register can take a new column this cycle
//   valid_o, pix_o     : registered texel output
module obj_pix_skid
  import obj_pkg::*;
(
  input  logic     clock_i,
  input  logic     reset_n_i,
  input  logic     ld_i,
  input  logic     emit_i,
  input  obj_pix_t pix_i,
  input  logic     ready_i,
  output logic     free_o,
  output logic     valid_o,
  output obj_pix_t pix_o
);

  logic     valid_q, valid_d;
  obj_pix_t pix_q, pix_d;

  // Empty, or the held entry leaves this cycle.
  assign free_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    pix_d   = pix_q;
    if (free_o) begin
      // A skipped column still clears a consumed entry.
      valid_d = ld_i && emit_i;
      if (ld_i && emit_i) pix_d = pix_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      pix_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pix_q   <= pix_d;
    end
  end

  assign valid_o = valid_q;
  assign pix_o   = pix_q;

endmodule

// File: rtl/obj_affine_sequencer.sv
// Per-object, per-scanline controller for the OBJ rotation/scaling unit.
// A start in IDLE captures the object, four OAM reads fetch PA..PD, then
// the bounding box is swept one column per cycle. Visible, non-transparent
// texels go to the tile fetcher through a one-entry valid/ready register.
// Ports:
//   clock_i, reset_n_i          : clock, synchronous active-low reset
//   start_i + object inputs     : obj_x/obj_y/row/hsize/vsize/double/param_idx
//   busy_o, done_o              : status; done is a one-cycle pulse
//   oam_rd_o/oam_addr_o/oam_rdata_i : affine parameter fetch (1-cycle latency)
//   rs_*_o / rs_*_i             : rot/scale unit interface (unit is external)
//   pix_valid_o/pix_ready_i/pix_*_o : texel request handshake
module obj_affine_sequencer
  import obj_pkg::*;
#(
  parameter int SCREEN_W = OBJ_SCREEN_W,
  parameter int OAM_AW   = 9
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              start_i,
  input  logic [8:0]        obj_x_i,
  input  logic [7:0]        obj_y_i,
  input  logic [7:0]        row_i,
  input  logic [7:0]        hsize_i,
  input  logic [7:0]        vsize_i,
  input  logic              double_size_i,
  input  logic [4:0]        param_idx_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              oam_rd_o,
  output logic [OAM_AW-1:0] oam_addr_o,
  input  logic [15:0]       oam_rdata_i,
  output logic [7:0]        rs_row_o,
  output logic [7:0]        rs_col_o,
  output logic [15:0]       rs_a_o,
  output logic [15:0]       rs_b_o,
  output logic [15:0]       rs_c_o,
  output logic [15:0]       rs_d_o,
  output logic [8:0]        rs_obj_x_o,
  output logic [7:0]        rs_obj_y_o,
  output logic [7:0]        rs_hsize_o,
  output logic [7:0]        rs_vsize_o,
  output logic              rs_double_o,
  input  logic [5:0]        rs_x_i,
  input  logic [5:0]        rs_y_i,
  input  logic              rs_transparent_i,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [7:0]        pix_screen_x_o,
  output logic [5:0]        pix_tex_x_o,
  output logic [5:0]        pix_tex_y_o
);

  logic [1:0]  state_q, state_d;
  obj_attr_t   attr_q, attr_d;
  logic [1:0]  k_q, k_d;          // FETCH beat
  logic [8:0]  col_q, col_d;      // current screen column, wraps mod 512
  logic [7:0]  cnt_q, cnt_d;      // columns already evaluated
  logic        cap_vld_q, cap_vld_d;  // oam_rdata holds a parameter
  logic [1:0]  cap_idx_q, cap_idx_d;  // ... and which one
  logic [15:0] pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;
  logic        done_q, done_d;

  logic        free, run, emit, col_vis;
  logic [7:0]  w_cap, h_cap, w_half, h_half;
  obj_pix_t    pix_in, pix_out;

  // Bounding box of the object being captured
  assign w_cap  = double_size_i ? {hsize_i[6:0], 1'b0} : hsize_i;
  assign h_cap  = double_size_i ? {vsize_i[6:0], 1'b0} : vsize_i;
  assign w_half = double_size_i ? hsize_i : {1'b0, hsize_i[7:1]};
  assign h_half = double_size_i ? vsize_i : {1'b0, vsize_i[7:1]};

  assign run     = (state_q == ST_RUN);
  assign col_vis = ({23'd0, col_q} < 32'(SCREEN_W));
  assign emit    = col_vis && !rs_transparent_i;
  assign pix_in  = '{sx: col_q[7:0], tx: rs_x_i, ty: rs_y_i};

  always_comb begin
    state_d   = state_q;
    attr_d    = attr_q;
    k_d       = k_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    // Read issued in beat k returns on the next cycle.
    cap_vld_d = (state_q == ST_FETCH);
    cap_idx_d = k_q;
    pa_d      = pa_q;
    pb_d      = pb_q;
    pc_d      = pc_q;
    pd_d      = pd_q;

    if (cap_vld_q) begin
      case (cap_idx_q)
        2'd0:    pa_d = oam_rdata_i;
        2'd1:    pb_d = oam_rdata_i;
        2'd2:    pc_d = oam_rdata_i;
        default: pd_d = oam_rdata_i;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          attr_d.row  = row_i;
          attr_d.w    = w_cap;
          attr_d.h    = h_cap;
          attr_d.cx   = obj_x_i + {1'b0, w_half};
          attr_d.cy   = obj_y_i + h_half;
          attr_d.dbl  = double_size_i;
          attr_d.pidx = param_idx_i;
          col_d       = obj_x_i;
          cnt_d       = 8'd0;
          k_d         = 2'd0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A held output register freezes the sweep.
        if (free) begin
          col_d = col_q + 9'd1;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == attr_q.w - 8'd1) state_d = ST_DRAIN;
        end
      end
      default: begin
        if (free) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      attr_q    <= '0;
      k_q       <= 2'd0;
      col_q     <= 9'd0;
      cnt_q     <= 8'd0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= 2'd0;
      pa_q      <= 16'd0;
      pb_q      <= 16'd0;
      pc_q      <= 16'd0;
      pd_q      <= 16'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      attr_q    <= attr_d;
      k_q       <= k_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
      pa_q      <= pa_d;
      pb_q      <= pb_d;
      pc_q      <= pc_d;
      pd_q      <= pd_d;
      done_q    <= done_d;
    end
  end

  obj_pix_skid u_skid (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .ld_i      (run),
    .emit_i    (emit),
    .pix_i     (pix_in),
    .ready_i   (pix_ready_i),
    .free_o    (free),
    .valid_o   (pix_valid_o),
    .pix_o     (pix_out)
  );

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign oam_rd_o   = (state_q == ST_FETCH);
  assign oam_addr_o = oam_rd_o ? OAM_AW'(aff_addr(attr_q.pidx, k_q)) : '0;

  assign rs_row_o    = attr_q.row;
  assign rs_col_o    = col_q[7:0];
  assign rs_a_o      = pa_q;
  assign rs_b_o      = pb_q;
  assign rs_c_o      = pc_q;
  // PD is still on the read bus during the first RUN cycle; forward it so
  // the first column is evaluated with the full parameter set.
  assign rs_d_o      = (cap_vld_q && cap_idx_q == 2'd3) ? oam_rdata_i : pd_q;
  assign rs_obj_x_o  = attr_q.cx;
  assign rs_obj_y_o  = attr_q.cy;
  assign rs_hsize_o  = attr_q.w;
  assign rs_vsize_o  = attr_q.h;
  assign rs_double_o = attr_q.dbl;

  assign pix_screen_x_o = pix_out.sx;
  assign pix_tex_x_o    = pix_out.tx;
  assign pix_tex_y_o    = pix_out.ty;

endmodule

// File: tb/tb_obj_affine_sequencer.sv
module tb_obj_affine_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  obj_x = '0;
  logic [7:0]  obj_y = '0, row = '0, hsize = 8'd8, vsize = 8'd8;
  logic        double_size = 1'b0;
  logic [4:0]  param_idx = '0;
  logic        busy, done, oam_rd;
  logic [8:0]  oam_addr;
  logic [15:0] oam_rdata;
  logic [7:0]  rs_row, rs_col, rs_obj_y, rs_hsize, rs_vsize;
  logic [15:0] rs_a, rs_b, rs_c, rs_d;
  logic [8:0]  rs_obj_x;
  logic        rs_double;
  logic [5:0]  rs_x, rs_y;
  logic        rs_transparent;
  logic        pix_valid, pix_ready = 1'b1;
  logic [7:0]  pix_screen_x;
  logic [5:0]  pix_tex_x, pix_tex_y;

  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  obj_affine_sequencer dut (
    .clock_i(clock), .reset_n_i(reset_n), .start_i(start),
    .obj_x_i(obj_x), .obj_y_i(obj_y), .row_i(row), .hsize_i(hsize),
    .vsize_i(vsize), .double_size_i(double_size), .param_idx_i(param_idx),
    .busy_o(busy), .done_o(done), .oam_rd_o(oam_rd), .oam_addr_o(oam_addr),
    .oam_rdata_i(oam_rdata), .rs_row_o(rs_row), .rs_col_o(rs_col),
    .rs_a_o(rs_a), .rs_b_o(rs_b), .rs_c_o(rs_c), .rs_d_o(rs_d),
    .rs_obj_x_o(rs_obj_x), .rs_obj_y_o(rs_obj_y), .rs_hsize_o(rs_hsize),
    .rs_vsize_o(rs_vsize), .rs_double_o(rs_double), .rs_x_i(rs_x),
    .rs_y_i(rs_y), .rs_transparent_i(rs_transparent),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
    .pix_screen_x_o(pix_screen_x), .pix_tex_x_o(pix_tex_x),
    .pix_tex_y_o(pix_tex_y)
  );

  // OAM: synchronous read, data one cycle after the strobe
  logic [15:0] oam [512];
  always @(posedge clock) if (oam_rd) oam_rdata <= oam[oam_addr];

  // Rot/scale unit stand-in: texel = M * (pos - center) + objsize/2
  logic [8:0] dx9;
  logic [7:0] dy8;
  int dx, dy, tx, ty, ow, oh;
  always_comb begin
    ow  = rs_double ? int'(rs_hsize) / 2 : int'(rs_hsize);
    oh  = rs_double ? int'(rs_vsize) / 2 : int'(rs_vsize);
    dx9 = {1'b0, rs_col} - rs_obj_x;
    dy8 = rs_row - rs_obj_y;
    dx  = int'($signed(dx9));
    dy  = int'($signed(dy8));
    tx  = ((int'($signed(rs_a)) * dx + int'($signed(rs_b)) * dy) >>> 8) + ow / 2;
    ty  = ((int'($signed(rs_c)) * dx + int'($signed(rs_d)) * dy) >>> 8) + oh / 2;
    rs_x = tx[5:0];
    rs_y = ty[5:0];
    rs_transparent = (tx < 0) || (tx >= ow) || (ty < 0) || (ty >= oh);
  end

  typedef struct packed {
    logic [7:0] sx;
    logic [5:0] tx;
    logic [5:0] ty;
  } px_t;
  px_t pq[$];

  // Record every accepted texel
  always @(negedge clock)
    if (pix_valid === 1'b1 && pix_ready === 1'b1)
      pq.push_back('{sx: pix_screen_x, tx: pix_tex_x, ty: pix_tex_y});

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic start_obj(input logic [8:0] ox, input logic [7:0] oy,
                           input logic [7:0] rw, input logic dbl,
                           input logic [4:0] pi);
    obj_x = ox; obj_y = oy; row = rw; hsize = 8'd8; vsize = 8'd8;
    double_size = dbl; param_idx = pi;
    pq.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps until done; c counts cycles with the start cycle as 1, -1 on timeout
  task automatic wait_done(input int c0, output int c);
    c = c0;
    for (int i = 0; i < 400; i++) begin
      step();
      c++;
      if (done === 1'b1) return;
    end
    c = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    n_cmp++;
    if ({busy, done, oam_rd, pix_valid} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, oam_rd, pix_valid});
    end
    n_cmp++;
    if ({oam_addr, rs_obj_x, rs_hsize, rs_col, rs_d} !== '0) begin
      n_bad++; $display("FAIL reset_data: got addr=%0d objx=%0d hs=%0d col=%0d d=%h expected all 0",
                        oam_addr, rs_obj_x, rs_hsize, rs_col, rs_d);
    end
    n_cmp++;
    if ({pix_screen_x, pix_tex_x, pix_tex_y} !== '0) begin
      n_bad++; $display("FAIL reset_pix: got %h expected 0", {pix_screen_x, pix_tex_x, pix_tex_y});
    end
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_identity();
    int cyc;
    px_t e;
    start_obj(9'd10, 8'd20, 8'd23, 1'b0, 5'd2);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({oam_rd, oam_addr} !== {1'b1, 9'(35 + 4 * k)}) begin
        n_bad++; $display("FAIL id_oam_addr%0d: got rd=%b addr=%0d expected rd=1 addr=%0d", k, oam_rd, oam_addr, 35 + 4 * k);
      end
      if (k < 3) step();
    end
    n_cmp++;
    if ({rs_hsize, rs_vsize, rs_obj_x, rs_obj_y, rs_row} !== {8'd8, 8'd8, 9'd14, 8'd24, 8'd23}) begin
      n_bad++; $display("FAIL id_box: got hs=%0d vs=%0d cx=%0d cy=%0d row=%0d expected 8 8 14 24 23",
                        rs_hsize, rs_vsize, rs_obj_x, rs_obj_y, rs_row);
    end
    wait_done(4, cyc);
    n_cmp++;
    if (cyc !== 14) begin n_bad++; $display("FAIL id_done_cycle: got %0d expected 14", cyc); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL id_busy_at_done: got %b expected 0", busy); end
    step();
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL id_done_pulse: got %b expected 0", done); end
    n_cmp++;
    if (pq.size() !== 8) begin n_bad++; $display("FAIL id_pix_count: got %0d expected 8", pq.size()); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      e.sx = 8'(10 + i); e.tx = 6'(i); e.ty = 6'd3;
      n_cmp++;
      if (pq[i] !== e) begin n_bad++; $display("FAIL id_pix%0d: got %h expected %h", i, pq[i], e); end
    end
  endtask

  task automatic test_double();
    int cyc;
    px_t e;
    start_obj(9'd10, 8'd20, 8'd27, 1'b1, 5'd2);
    n_cmp++;
    if ({rs_hsize, rs_vsize, rs_obj_x, rs_obj_y, rs_double} !== {8'd16, 8'd16, 9'd18, 8'd28, 1'b1}) begin
      n_bad++; $display("FAIL dbl_box: got hs=%0d vs=%0d cx=%0d cy=%0d dbl=%b expected 16 16 18 28 1",
                        rs_hsize, rs_vsize, rs_obj_x, rs_obj_y, rs_double);
    end
    wait_done(1, cyc);
    n_cmp++;
    if (cyc !== 22) begin n_bad++; $display("FAIL dbl_done_cycle: got %0d expected 22", cyc); end
    n_cmp++;
    if (pq.size() !== 8) begin n_bad++; $display("FAIL dbl_pix_count: got %0d expected 8", pq.size()); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      e.sx = 8'(14 + i); e.tx = 6'(i); e.ty = 6'd3;
      n_cmp++;
      if (pq[i] !== e) begin n_bad++; $display("FAIL dbl_pix%0d: got %h expected %h", i, pq[i], e); end
    end
  endtask

  task automatic test_right_edge();
    int cyc;
    px_t e;
    start_obj(9'd236, 8'd20, 8'd23, 1'b0, 5'd2);
    wait_done(1, cyc);
    n_cmp++;
    if (cyc !== 14) begin n_bad++; $display("FAIL redge_done_cycle: got %0d expected 14", cyc); end
    n_cmp++;
    if (pq.size() !== 4) begin n_bad++; $display("FAIL redge_pix_count: got %0d expected 4", pq.size()); end
    for (int i = 0; i < 4 && i < pq.size(); i++) begin
      e.sx = 8'(236 + i); e.tx = 6'(i); e.ty = 6'd3;
      n_cmp++;
      if (pq[i] !== e) begin n_bad++; $display("FAIL redge_pix%0d: got %h expected %h", i, pq[i], e); end
    end
  endtask

  task automatic test_left_wrap();
    int cyc;
    px_t e;
    start_obj(9'd508, 8'd20, 8'd23, 1'b0, 5'd2);
    n_cmp++;
    if (rs_obj_x !== 9'd0) begin n_bad++; $display("FAIL lwrap_center: got %0d expected 0", rs_obj_x); end
    wait_done(1, cyc);
    n_cmp++;
    if (cyc !== 14) begin n_bad++; $display("FAIL lwrap_done_cycle: got %0d expected 14", cyc); end
    n_cmp++;
    if (pq.size() !== 4) begin n_bad++; $display("FAIL lwrap_pix_count: got %0d expected 4", pq.size()); end
    for (int i = 0; i < 4 && i < pq.size(); i++) begin
      e.sx = 8'(i); e.tx = 6'(4 + i); e.ty = 6'd3;
      n_cmp++;
      if (pq[i] !== e) begin n_bad++; $display("FAIL lwrap_pix%0d: got %h expected %h", i, pq[i], e); end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    px_t e, snap, now;
    start_obj(9'd10, 8'd20, 8'd23, 1'b0, 5'd2);
    for (int i = 0; i < 7; i++) step();
    // cycle 8: the texel for column 12 is on the output
    pix_ready = 1'b0;
    snap = '{sx: pix_screen_x, tx: pix_tex_x, ty: pix_tex_y};
    e.sx = 8'd12; e.tx = 6'd2; e.ty = 6'd3;
    n_cmp++;
    if ({pix_valid, snap} !== {1'b1, e}) begin
      n_bad++; $display("FAIL bp_held_pix: got v=%b %h expected v=1 %h", pix_valid, snap, e);
    end
    for (int s = 0; s < 3; s++) begin
      step();
      now = '{sx: pix_screen_x, tx: pix_tex_x, ty: pix_tex_y};
      n_cmp++;
      if ({pix_valid, now} !== {1'b1, snap}) begin
        n_bad++; $display("FAIL bp_stable%0d: got v=%b %h expected v=1 %h", s, pix_valid, now, snap);
      end
    end
    pix_ready = 1'b1;
    wait_done(11, cyc);
    n_cmp++;
    if (cyc !== 17) begin n_bad++; $display("FAIL bp_done_cycle: got %0d expected 17", cyc); end
    n_cmp++;
    if (pq.size() !== 8) begin n_bad++; $display("FAIL bp_pix_count: got %0d expected 8", pq.size()); end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      e.sx = 8'(10 + i); e.tx = 6'(i); e.ty = 6'd3;
      n_cmp++;
      if (pq[i] !== e) begin n_bad++; $display("FAIL bp_pix%0d: got %h expected %h", i, pq[i], e); end
    end
  endtask

  task automatic test_params();
    int cyc;
    start_obj(9'd40, 8'd20, 8'd23, 1'b0, 5'd7);
    wait_done(1, cyc);
    n_cmp++;
    if (cyc !== 14) begin n_bad++; $display("FAIL prm_done_cycle: got %0d expected 14", cyc); end
    n_cmp++;
    if ({rs_a, rs_b, rs_c, rs_d} !== 64'h1111_2222_3333_4444) begin
      n_bad++; $display("FAIL prm_abcd: got %h %h %h %h expected 1111 2222 3333 4444", rs_a, rs_b, rs_c, rs_d);
    end
  endtask

  task automatic test_start_busy();
    int cyc;
    start_obj(9'd10, 8'd20, 8'd23, 1'b0, 5'd2);
    for (int i = 0; i < 5; i++) step();
    obj_x = 9'd100; row = 8'd50; hsize = 8'd16; double_size = 1'b1; param_idx = 5'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({rs_obj_x, rs_hsize, rs_row, rs_double, rs_a} !== {9'd14, 8'd8, 8'd23, 1'b0, 16'h0100}) begin
      n_bad++; $display("FAIL sb_attrs: got cx=%0d hs=%0d row=%0d dbl=%b a=%h expected 14 8 23 0 0100",
                        rs_obj_x, rs_hsize, rs_row, rs_double, rs_a);
    end
    wait_done(7, cyc);
    n_cmp++;
    if (cyc !== 14) begin n_bad++; $display("FAIL sb_done_cycle: got %0d expected 14", cyc); end
    n_cmp++;
    if (pq.size() !== 8) begin n_bad++; $display("FAIL sb_pix_count: got %0d expected 8", pq.size()); end
    for (int s = 0; s < 3; s++) step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL sb_no_restart: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_run();
    int ndone, nvalid;
    start_obj(9'd10, 8'd20, 8'd23, 1'b0, 5'd2);
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    step();
    n_cmp++;
    if ({busy, pix_valid, done, oam_rd} !== 4'b0) begin
      n_bad++; $display("FAIL rr_flags: got busy=%b v=%b done=%b rd=%b expected 0", busy, pix_valid, done, oam_rd);
    end
    n_cmp++;
    if ({rs_obj_x, rs_hsize, rs_a, pix_screen_x} !== '0) begin
      n_bad++; $display("FAIL rr_data: got cx=%0d hs=%0d a=%h sx=%0d expected 0", rs_obj_x, rs_hsize, rs_a, pix_screen_x);
    end
    reset_n = 1'b1;
    ndone = 0; nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done === 1'b1) ndone++;
      if (pix_valid === 1'b1) nvalid++;
    end
    n_cmp++;
    if ({ndone, nvalid} !== {32'd0, 32'd0}) begin
      n_bad++; $display("FAIL rr_quiet: got done=%0d valid=%0d expected 0 0", ndone, nvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) oam[i] = 16'h0000;
    for (int p = 0; p < 32; p++) begin
      oam[16 * p + 3]  = 16'h0100;
      oam[16 * p + 15] = 16'h0100;
    end
    oam[115] = 16'h1111; oam[119] = 16'h2222;
    oam[123] = 16'h3333; oam[127] = 16'h4444;

    test_reset();
    test_identity();
    test_double();
    test_right_edge();
    test_left_wrap();
    test_backpressure();
    test_params();
    test_start_busy();
    test_reset_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
